// File: rtl/store_narrow32_if.sv
// Data-memory port of the store narrowing unit: word address, read/write
// strobes, write data, read data and the shared completion signal.
interface store_narrow32_if #(
    parameter int ADDR_W = 30
);
    logic [ADDR_W-1:0] M_Addr;
    logic              M_Rd;
    logic              M_Wr;
    logic [31:0]       M_WData;
    logic [31:0]       M_RData;
    logic              M_Ready;

    // Strobe handshake: a strobe (M_Rd or M_Wr) stays high until M_Ready is
    // seen with it on a rising edge; M_RData is valid when M_Rd and M_Ready
    // are both high; M_Ready is ignored while no strobe is active.
    modport master (
        output M_Addr, M_Rd, M_Wr, M_WData,
        input  M_RData, M_Ready
    );

    modport slave (
        input  M_Addr, M_Rd, M_Wr, M_WData,
        output M_RData, M_Ready
    );
endinterface

// File: rtl/store_narrow32.sv
// Store-side narrowing unit: truncates a 32-bit operand to byte/half/word,
// writes it into word-only memory (read-modify-write for sub-word sizes) and
// flags operands that the truncation does not represent faithfully.
module store_narrow32 #(
    parameter int ADDR_W = 30
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        Req,
    input  logic [31:0] Addr,
    input  logic [31:0] D,
    input  logic [1:0]  Size,
    input  logic        Se,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic        Tr,
    output logic [2:0]  dbg_state,
    store_narrow32_if.master mem
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ERR   = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] word_addr_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic [31:0]       d_q;
    logic [31:0]       old_q;
    logic              err_q;
    logic              tr_q;
    logic              req_err;
    logic              req_tr;
    logic              accept;
    logic [31:0]       merged;

    assign accept    = (state_q == S_IDLE) && Req;
    assign dbg_state = state_q;

    // Classify the incoming request: illegal size or misalignment, and whether
    // the operand survives truncation under the requested signedness.
    always_comb begin
        req_err = (Size == 2'b11)
                || ((Size == 2'b01) && Addr[0])
                || ((Size == 2'b10) && (Addr[1:0] != 2'b00));
        req_tr  = 1'b0;
        case (Size)
            2'b00:   req_tr = Se ? !((&D[31:7])  || (~|D[31:7]))  : (|D[31:8]);
            2'b01:   req_tr = Se ? !((&D[31:15]) || (~|D[31:15])) : (|D[31:16]);
            default: req_tr = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    if (req_err)            state_d = S_ERR;
                    else if (Size == 2'b10) state_d = S_WRITE;
                    else                    state_d = S_READ;
                end
            end
            S_ERR:   state_d = S_DONE;
            S_READ:  if (mem.M_Ready) state_d = S_WRITE;
            S_WRITE: if (mem.M_Ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch: address, operand, size and the precomputed flags.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            word_addr_q <= '0;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            d_q         <= 32'h0;
            err_q       <= 1'b0;
            tr_q        <= 1'b0;
        end else if (accept) begin
            word_addr_q <= Addr[ADDR_W+1:2];
            lane_q      <= Addr[1:0];
            size_q      <= Size;
            d_q         <= D;
            err_q       <= req_err;
            tr_q        <= req_tr && !req_err;
        end
    end

    // Old-word register for the read-modify-write merge.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn)                                    old_q <= 32'h0;
        else if ((state_q == S_READ) && mem.M_Ready)  old_q <= mem.M_RData;
    end

    // Merge the truncated operand into the selected little-endian lane.
    always_comb begin
        merged = old_q;
        case (size_q)
            2'b00: merged[{lane_q, 3'b000} +: 8] = d_q[7:0];
            2'b01: begin
                if (lane_q[1]) merged[31:16] = d_q[15:0];
                else           merged[15:0]  = d_q[15:0];
            end
            2'b10:   merged = d_q;
            default: merged = old_q;
        endcase
    end

    // Outputs decoded from state and registered values only.
    always_comb begin
        Busy        = (state_q != S_IDLE);
        Done        = (state_q == S_DONE);
        Err         = (state_q == S_DONE) && err_q;
        Tr          = (state_q == S_DONE) && tr_q;
        mem.M_Rd    = (state_q == S_READ);
        mem.M_Wr    = (state_q == S_WRITE);
        mem.M_Addr  = word_addr_q;
        mem.M_WData = merged;
    end
endmodule

// File: tb/tb_store_narrow32.sv
// Directed bench for store_narrow32: a small word memory model answers the
// strobes, each store's timing, merge data and flags are compared against
// hand-computed values.
module tb_store_narrow32;
    logic        Clk;
    logic        Clrn;
    logic        Req;
    logic [31:0] Addr;
    logic [31:0] D;
    logic [1:0]  Size;
    logic        Se;
    logic        Busy, Done, Err, Tr;
    logic [2:0]  dbg_state;

    store_narrow32_if #(.ADDR_W(30)) mem_if ();

    store_narrow32 #(.ADDR_W(30)) dut (
        .Clk       (Clk),
        .Clrn      (Clrn),
        .Req       (Req),
        .Addr      (Addr),
        .D         (D),
        .Size      (Size),
        .Se        (Se),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .Tr        (Tr),
        .dbg_state (dbg_state),
        .mem       (mem_if)
    );

    logic [31:0] mem [16];
    int          n_checks = 0;
    int          n_errors = 0;

    // Clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one store, play the memory, and report what the unit did.
    task automatic run_store(
        input  logic [31:0] addr,
        input  logic [31:0] d,
        input  logic [1:0]  size,
        input  logic        se,
        input  int          rd_wait,
        input  int          wr_wait,
        input  bit          pulse_req,
        output int          done_cyc,
        output logic        err_o,
        output logic        tr_o,
        output logic [31:0] wdata_o,
        output logic [29:0] waddr_o,
        output int          rd_cnt,
        output int          wr_cnt
    );
        int rd_seen;
        int wr_seen;
        bit overlap;
        bit stray_flag;
        rd_seen = 0; wr_seen = 0; overlap = 0; stray_flag = 0;
        done_cyc = -1; err_o = 1'bx; tr_o = 1'bx;
        wdata_o = 32'h0; waddr_o = 30'h0; rd_cnt = 0; wr_cnt = 0;
        @(negedge Clk);
        Addr = addr; D = d; Size = size; Se = se; Req = 1'b1;
        mem_if.M_Ready = 1'b0;
        @(posedge Clk);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge Clk);
            Req = 1'b0;
            if (pulse_req && cyc == 2) begin
                Req = 1'b1; Size = 2'b10; Addr = 32'h0000_0030; D = 32'h0BAD_0BAD;
            end
            if (mem_if.M_Rd && mem_if.M_Wr) overlap = 1;
            mem_if.M_Ready = 1'b0;
            if (mem_if.M_Rd) begin
                rd_cnt++;
                mem_if.M_RData = mem[mem_if.M_Addr[3:0]];
                if (rd_seen >= rd_wait) mem_if.M_Ready = 1'b1;
                rd_seen++;
            end
            if (mem_if.M_Wr) begin
                wr_cnt++;
                wdata_o = mem_if.M_WData;
                waddr_o = mem_if.M_Addr;
                if (wr_seen >= wr_wait) begin
                    mem_if.M_Ready = 1'b1;
                    mem[mem_if.M_Addr[3:0]] = mem_if.M_WData;
                end
                wr_seen++;
            end
            if (Done) begin
                done_cyc = cyc; err_o = Err; tr_o = Tr;
                break;
            end
            if (Err || Tr) stray_flag = 1;
        end
        check("strobe_overlap", {31'h0, overlap}, 32'h0);
        check("flag_outside_done", {31'h0, stray_flag}, 32'h0);
        @(negedge Clk);
        mem_if.M_Ready = 1'b0;
        check("idle_after_done", {31'h0, Busy}, 32'h0);
    endtask

    int          dc, rc, wc;
    logic        e, t;
    logic [31:0] wd;
    logic [29:0] wa;

    initial begin
        Clrn = 1'b0; Req = 1'b0; Addr = 32'h0; D = 32'h0; Size = 2'b00; Se = 1'b0;
        mem_if.M_Ready = 1'b0; mem_if.M_RData = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        #12;
        // Reset state.
        check("rst_busy",  {31'h0, Busy}, 32'h0);
        check("rst_done",  {31'h0, Done}, 32'h0);
        check("rst_flags", {30'h0, Err, Tr}, 32'h0);
        check("rst_strobes", {30'h0, mem_if.M_Rd, mem_if.M_Wr}, 32'h0);
        check("rst_maddr", {2'b00, mem_if.M_Addr}, 32'h0);
        check("rst_wdata", mem_if.M_WData, 32'h0);
        check("rst_state", {29'h0, dbg_state}, 32'h0);
        @(negedge Clk);
        Clrn = 1'b1;

        // Word store, zero wait.
        run_store(32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, 0, 0, dc, e, t, wd, wa, rc, wc);
        check("word_done_cyc", dc, 2);
        check("word_rd_cnt", rc, 0);
        check("word_wr_cnt", wc, 1);
        check("word_addr", {2'b00, wa}, 32'h4);
        check("word_wdata", wd, 32'hDEAD_BEEF);
        check("word_err_tr", {30'h0, e, t}, 32'h0);

        // Byte merge into lane 2.
        mem[5] = 32'h1122_3344;
        run_store(32'h0000_0016, 32'h0000_00AB, 2'b00, 1'b0, 0, 0, 0, dc, e, t, wd, wa, rc, wc);
        check("byte_done_cyc", dc, 3);
        check("byte_rd_wr", {rc[15:0], wc[15:0]}, {16'd1, 16'd1});
        check("byte_wdata", wd, 32'h11AB_3344);
        check("byte_err_tr", {30'h0, e, t}, 32'h0);

        // Half merge, signed, value not representable.
        mem[6] = 32'hAAAA_BBBB;
        run_store(32'h0000_001A, 32'h0001_8000, 2'b01, 1'b1, 0, 0, 0, dc, e, t, wd, wa, rc, wc);
        check("half_s_done_cyc", dc, 3);
        check("half_s_wdata", wd, 32'h8000_BBBB);
        check("half_s_err_tr", {30'h0, e, t}, 32'h1);

        // Same half, sign-extended operand: no truncation flag.
        mem[6] = 32'hAAAA_BBBB;
        run_store(32'h0000_001A, 32'hFFFF_8000, 2'b01, 1'b1, 0, 0, 0, dc, e, t, wd, wa, rc, wc);
        check("half_s2_wdata", wd, 32'h8000_BBBB);
        check("half_s2_err_tr", {30'h0, e, t}, 32'h0);

        // Signed byte into lane 3 that overflows.
        mem[8] = 32'h5566_7788;
        run_store(32'h0000_0023, 32'h0000_0080, 2'b00, 1'b1, 0, 0, 0, dc, e, t, wd, wa, rc, wc);
        check("byte3_addr", {2'b00, wa}, 32'h8);
        check("byte3_wdata", wd, 32'h8066_7788);
        check("byte3_err_tr", {30'h0, e, t}, 32'h1);

        // Unsigned half, low lane, fits; then one that does not fit.
        mem[9] = 32'hCAFE_F00D;
        run_store(32'h0000_0024, 32'h0000_BEEF, 2'b01, 1'b0, 0, 0, 0, dc, e, t, wd, wa, rc, wc);
        check("half_u_wdata", wd, 32'hCAFE_BEEF);
        check("half_u_err_tr", {30'h0, e, t}, 32'h0);
        run_store(32'h0000_0024, 32'h0001_0000, 2'b01, 1'b0, 0, 0, 0, dc, e, t, wd, wa, rc, wc);
        check("half_u2_wdata", wd, 32'hCAFE_0000);
        check("half_u2_err_tr", {30'h0, e, t}, 32'h1);

        // Misaligned half, misaligned word, illegal size.
        run_store(32'h0000_0021, 32'h0000_1234, 2'b01, 1'b0, 0, 0, 0, dc, e, t, wd, wa, rc, wc);
        check("err_half_cyc", dc, 2);
        check("err_half_flags", {30'h0, e, t}, 32'h2);
        check("err_half_mem", {rc[15:0], wc[15:0]}, 32'h0);
        run_store(32'h0000_0022, 32'h1234_5678, 2'b10, 1'b0, 0, 0, 0, dc, e, t, wd, wa, rc, wc);
        check("err_word_cyc", dc, 2);
        check("err_word_flags", {30'h0, e, t}, 32'h2);
        check("err_word_mem", {rc[15:0], wc[15:0]}, 32'h0);
        run_store(32'h0000_0020, 32'hFFFF_FFFF, 2'b11, 1'b1, 0, 0, 0, dc, e, t, wd, wa, rc, wc);
        check("err_size_cyc", dc, 2);
        check("err_size_flags", {30'h0, e, t}, 32'h2);
        check("err_size_mem", {rc[15:0], wc[15:0]}, 32'h0);

        // Wait states (3 in READ, 2 in WRITE) with a stray Req while busy.
        mem[7] = 32'h0102_0304;
        mem[12] = 32'h0;
        run_store(32'h0000_001C, 32'h0001_2345, 2'b00, 1'b0, 3, 2, 1, dc, e, t, wd, wa, rc, wc);
        check("wait_done_cyc", dc, 8);
        check("wait_rd_wr", {rc[15:0], wc[15:0]}, {16'd4, 16'd3});
        check("wait_wdata", wd, 32'h0102_0345);
        check("wait_err_tr", {30'h0, e, t}, 32'h1);
        check("wait_stray_mem", mem[12], 32'h0);

        // Asynchronous reset while in WRITE with the memory stalling.
        mem[10] = 32'h1111_1111;
        @(negedge Clk);
        Addr = 32'h0000_0028; D = 32'h0000_005A; Size = 2'b00; Se = 1'b0; Req = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Req = 1'b0;
        check("rst_mid_rd", {31'h0, mem_if.M_Rd}, 32'h1);
        mem_if.M_RData = mem[10];
        mem_if.M_Ready = 1'b1;
        @(negedge Clk);
        check("rst_mid_wr", {31'h0, mem_if.M_Wr}, 32'h1);
        mem_if.M_Ready = 1'b0;
        #2 Clrn = 1'b0;
        #1;
        check("rst_mid_drop", {29'h0, mem_if.M_Wr, Busy, Done}, 32'h0);
        @(negedge Clk);
        Clrn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("rst_no_done", {30'h0, Busy, Done}, 32'h0);
        end
        run_store(32'h0000_0028, 32'h0000_005A, 2'b00, 1'b0, 0, 0, 0, dc, e, t, wd, wa, rc, wc);
        check("post_rst_cyc", dc, 3);
        check("post_rst_wdata", wd, 32'h1111_115A);
        check("post_rst_mem", mem[10], 32'h1111_115A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/store_narrow32.md
# store_narrow32

Store-side narrowing unit for the multi-cycle datapath: truncates a 32-bit register operand to byte, halfword or word and writes it into a word-only data memory, using read-modify-write for sub-word sizes. It is the inverse of the load-path 16→32 zero/sign extension. It sits between the datapath's store control (`Req`/`Size`/`Se`) and the data-memory port. It also flags operands that the truncation does not represent faithfully under the requested signedness.

## Interface
- `ADDR_W`, default 30: word-address width on the memory port; the unit drives `Addr[ADDR_W+1:2]`.
- `Clk`  in  1  rising-edge clock.
- `Clrn`  in  1  asynchronous, active-low reset.
- `Req`  in  1  store request; sampled only in IDLE.
- `Addr`  in  32  byte address of the store.
- `D`  in  32  store operand (rt value).
- `Size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `Se`  in  1  1 = signed range check, 0 = unsigned range check.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle completion pulse.
- `Err`  out  1  high with `Done` on a misaligned or illegal request; no memory access occurs.
- `Tr`  out  1  high with `Done` when the truncation lost information.
- `M_Addr`  out  ADDR_W  word address.
- `M_Rd`  out  1  read strobe; held until `M_Ready`.
- `M_Wr`  out  1  write strobe; held until `M_Ready`.
- `M_WData`  out  32  write data.
- `M_RData`  in  32  read data; valid when `M_Rd` and `M_Ready` are both high.
- `M_Ready`  in  1  memory completion for the current strobe; ignored when no strobe is active.

## Operation
- States:
  - IDLE: `Req` = 1 latches `Addr`, `D`, `Size` and `Se`. Next state is ERR if the request is illegal, WRITE for a word store, READ otherwise.
  - ERR: one cycle, then DONE.
  - READ: assert `M_Rd`. When `M_Ready` = 1, capture `M_RData` into the old-word register and go to WRITE.
  - WRITE: assert `M_Wr` with the merged word. When `M_Ready` = 1, go to DONE.
  - DONE: one cycle, then IDLE.
- Illegal requests:
  - `Size` = 11.
  - Half with `Addr[0]` = 1.
  - Word with `Addr[1:0]` ≠ 00.
- Byte lanes are little-endian. Byte at `Addr[1:0]` = k occupies bits [8k+7:8k]. Half at `Addr[1]` = 0 occupies [15:0]; at `Addr[1]` = 1 it occupies [31:16].
- Merge: `M_WData` = old word with the selected lane replaced by `D[7:0]` (byte) or `D[15:0]` (half); the other lanes are unchanged. For a word store, `M_WData` = `D` and no read is issued.
- `Tr` rule, for width n = 8 or 16:
  - `Se` = 1: `Tr` = 1 iff `D[31:n-1]` is not all-equal (the value is not the sign-extension of its low n bits).
  - `Se` = 0: `Tr` = 1 iff `D[31:n]` ≠ 0.
  - Word stores give `Tr` = 0.
  - `Tr` never suppresses the write.
- `M_Addr` = latched `Addr[ADDR_W+1:2]`, held constant from the first cycle after acceptance until IDLE.
- `Req` while `Busy` = 1 is ignored and is not queued. The requester holds `Req` until it sees `Busy` rise, or re-issues after `Done`.

## Timing
- Reset (`Clrn` = 0, asynchronous):
  - State goes to IDLE.
  - `Busy`, `Done`, `Err`, `Tr`, `M_Rd` and `M_Wr` go to 0.
  - `M_Addr`, `M_WData` and the internal registers go to 0.
  - A reset mid-READ or mid-WRITE drops the strobe immediately; the memory result is discarded.
- All outputs are registered or decoded from state only; no input-to-output combinational paths.
- Zero-wait memory (`M_Ready` = 1 whenever a strobe is high), with `Req` sampled at edge 0:
  - Word store: WRITE during cycle 1, DONE during cycle 2.
  - Sub-word store: READ during cycle 1, WRITE during cycle 2, DONE during cycle 3.
  - Error: ERR during cycle 1, DONE during cycle 2.
- Each wait cycle (`M_Ready` = 0) extends READ or WRITE by one cycle.
- `M_Rd` and `M_Wr` are never high in the same cycle.
- `Done`, `Err` and `Tr` are valid only in the DONE cycle; they are 0 in all other cycles.
- A new request is accepted no earlier than the cycle after DONE (back-to-back throughput: word 3 cycles, sub-word 4 cycles).

## Test plan
- Word store, zero-wait:
  - Stimulus: `Addr` = 0x0000_0010, `D` = 0xDEAD_BEEF, `Size` = 10.
  - Required: no `M_Rd`; one `M_Wr` cycle with `M_Addr` = 4 and `M_WData` = 0xDEAD_BEEF; `Done` in cycle 2; `Err` = 0, `Tr` = 0.
- Byte merge:
  - Stimulus: memory word 0x1122_3344, `Addr` = 0x…2, `D` = 0x0000_00AB, `Size` = 00, `Se` = 0.
  - Required: `M_WData` = 0x11AB_3344; `Tr` = 0; `Done` in cycle 3.
- Half merge with signed truncation flag:
  - Stimulus: old word 0xAAAA_BBBB, `Addr` = 0x…2, `D` = 0x0001_8000, `Se` = 1.
  - Required: `M_WData` = 0x8000_BBBB, `Tr` = 1.
  - Repeat with `D` = 0xFFFF_8000: `Tr` = 0.
- Misaligned and illegal requests:
  - Stimulus: half at `Addr` = 0x…1; word at `Addr` = 0x…2; `Size` = 11.
  - Required: each produces `Done` = `Err` = 1 in cycle 2, with `M_Rd` and `M_Wr` never asserted.
- Wait states and ignored `Req`:
  - Stimulus: `M_Ready` held low 3 cycles in READ and 2 cycles in WRITE; `Req` pulsed while `Busy` = 1.
  - Required: the strobes stay high until `M_Ready`; `Done` in cycle 8; the extra `Req` has no effect.
- Async reset mid-WRITE:
  - Stimulus: `Clrn` = 0 between clock edges while in WRITE.
  - Required: `M_Wr`, `Busy` and `Done` fall immediately; no `Done` pulse follows; the next `Req` after release is serviced normally.
